// File: rtl/key_expansion_pkg.sv
// Shared constants and types for the AES-128 round-key generator.
// Holds the round count, the Rcon table and the controller state encoding.
package key_expansion_pkg;

    localparam int NR_DEFAULT = 10;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Rcon[r] for r = 1..10; any other index yields zero.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] val;
        case (r)
            4'd1:    val = 8'h01;
            4'd2:    val = 8'h02;
            4'd3:    val = 8'h04;
            4'd4:    val = 8'h08;
            4'd5:    val = 8'h10;
            4'd6:    val = 8'h20;
            4'd7:    val = 8'h40;
            4'd8:    val = 8'h80;
            4'd9:    val = 8'h1b;
            4'd10:   val = 8'h36;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/key_expansion_if.sv
// Key load / round-key handshake bundle between the key source, the generator
// and the AddRoundKey consumer.
interface key_expansion_if;
    logic        start_in;
    logic [31:0] K0_in;
    logic [31:0] K1_in;
    logic [31:0] K2_in;
    logic [31:0] K3_in;
    logic        ready_in;
    logic [31:0] D0_out;
    logic [31:0] D1_out;
    logic [31:0] D2_out;
    logic [31:0] D3_out;
    logic        valid_out;
    logic [3:0]  round_out;
    logic        busy_out;
    logic        done_out;

    modport master (
        output start_in, K0_in, K1_in, K2_in, K3_in, ready_in,
        input  D0_out, D1_out, D2_out, D3_out, valid_out, round_out, busy_out, done_out
    );

    modport slave (
        input  start_in, K0_in, K1_in, K2_in, K3_in, ready_in,
        output D0_out, D1_out, D2_out, D3_out, valid_out, round_out, busy_out, done_out
    );
endinterface

// File: rtl/key_expansion_aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform, computed rather than tabulated.
module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] sub
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] a;
        p = 8'h00;
        a = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for nonzero x, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int k = 1; k < 8; k++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(data);
        sub = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/key_expansion.sv
// AES-128 key expansion: streams round keys 0..NR to a consumer, one per accepted transfer.
//   state  | meaning
//   IDLE   | waiting for start_in; outputs hold last values (zero after reset)
//   ACTIVE | round key presented; advances on valid_out & ready_in
module key_expansion
    import key_expansion_pkg::*;
#(
    parameter int NR = NR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    key_expansion_if.slave  bus
);

    state_t      state_q, state_d;
    logic [31:0] w0_q, w1_q, w2_q, w3_q;
    logic [31:0] w0_d, w1_d, w2_d, w3_d;
    logic [3:0]  round_q, round_d;
    logic        done_q, done_d;

    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] t_word;
    logic [31:0] n0, n1, n2, n3;

    assign rot_word = {w3_q[23:0], w3_q[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .data (rot_word[8*i +: 8]),
            .sub  (sub_word[8*i +: 8])
        );
    end

    assign t_word = sub_word ^ {rcon(round_q + 4'd1), 24'h000000};
    assign n0     = w0_q ^ t_word;
    assign n1     = w1_q ^ n0;
    assign n2     = w2_q ^ n1;
    assign n3     = w3_q ^ n2;

    always_comb begin
        state_d = state_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        w3_d    = w3_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    state_d = ACTIVE;
                    w0_d    = bus.K0_in;
                    w1_d    = bus.K1_in;
                    w2_d    = bus.K2_in;
                    w3_d    = bus.K3_in;
                    round_d = 4'd0;
                end
            end
            ACTIVE: begin
                // start_in is deliberately not looked at here.
                if (bus.ready_in) begin
                    if (round_q == 4'(NR)) begin
                        state_d = IDLE;
                        round_d = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        w0_d    = n0;
                        w1_d    = n1;
                        w2_d    = n2;
                        w3_d    = n3;
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w0_q    <= 32'h0;
            w1_q    <= 32'h0;
            w2_q    <= 32'h0;
            w3_q    <= 32'h0;
            round_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign bus.D0_out    = w0_q;
    assign bus.D1_out    = w1_q;
    assign bus.D2_out    = w2_q;
    assign bus.D3_out    = w3_q;
    assign bus.round_out = round_q;
    assign bus.valid_out = (state_q == ACTIVE);
    assign bus.busy_out  = (state_q == ACTIVE);
    assign bus.done_out  = done_q;

endmodule

// File: tb/tb_key_expansion.sv
// Scoreboard bench for key_expansion: a FIPS-197 style reference expansion feeds
// an expected-key queue that a negedge monitor drains on every transfer.
module tb_key_expansion;

    localparam int NR = 10;

    logic clk;
    logic rst_n;

    key_expansion_if bus ();

    key_expansion #(.NR(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_entry_t;

    exp_entry_t   sb_q[$];
    int           vectors;
    int           miscompares;
    logic [31:0]  mw[44];
    int           exp_tab[256];
    int           log_tab[256];
    logic [127:0] got_key[11];
    int           got_vcycle[11];

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Log/antilog tables over generator 3 give the field inverse.
    task automatic build_tables();
        logic [7:0] x;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_tab[i] = int'(x);
            log_tab[x] = i;
            x = x ^ xt(x);
        end
    endtask

    function automatic logic [7:0] sbox_ref(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] s;
        inv = (b == 8'h00) ? 8'h00 : 8'(exp_tab[(255 - log_tab[b]) % 255]);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                 ^ inv[(i + 7) % 8] ^ ((8'h63 >> i) & 8'h01) != 8'h00;
        return s;
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] temp;
        logic [7:0]  rc;
        rc = 8'h01;
        mw[0] = key[127:96];
        mw[1] = key[95:64];
        mw[2] = key[63:32];
        mw[3] = key[31:0];
        for (int i = 4; i < 44; i++) begin
            temp = mw[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_ref(temp[31:24]), sbox_ref(temp[23:16]),
                        sbox_ref(temp[15:8]), sbox_ref(temp[7:0])};
                temp = temp ^ {rc, 24'h0};
                rc = xt(rc);
            end
            mw[i] = mw[i-4] ^ temp;
        end
    endtask

    task automatic push_expected();
        exp_entry_t e;
        for (int r = 0; r <= NR; r++) begin
            e.rnd = 4'(r);
            e.key = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
            sb_q.push_back(e);
        end
        for (int r = 0; r <= NR; r++) begin
            got_key[r]    = '0;
            got_vcycle[r] = 0;
        end
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: decoupled from stimulus, compares every transfer against the queue.
    bit           exp_done;
    bit           prev_hold;
    bit           prev_valid;
    logic [131:0] prev_snap;
    int           valid_cnt;

    always @(negedge clk) begin
        exp_entry_t   e;
        logic [127:0] d_now;
        d_now = {bus.D0_out, bus.D1_out, bus.D2_out, bus.D3_out};
        if (!rst_n) begin
            check("reset_outputs", {d_now, bus.round_out, bus.valid_out, bus.busy_out, bus.done_out}, '0);
            exp_done   = 1'b0;
            prev_hold  = 1'b0;
            prev_valid = 1'b0;
            valid_cnt  = 0;
        end else begin
            check("done_pulse", 136'(bus.done_out), 136'(exp_done));
            check("busy_vs_valid", 136'(bus.busy_out), 136'(bus.valid_out));
            if (prev_hold)
                check("hold_stable", 136'({bus.round_out, d_now}), 136'(prev_snap));
            exp_done = 1'b0;
            if (bus.valid_out)
                valid_cnt = prev_valid ? valid_cnt + 1 : 1;
            if (bus.valid_out && bus.ready_in) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_transfer: round %0d presented with empty queue", bus.round_out);
                end else begin
                    e = sb_q.pop_front();
                    check("round_index", 136'(bus.round_out), 136'(e.rnd));
                    check("round_key", 136'(d_now), 136'(e.key));
                    if (e.rnd == 4'(NR)) exp_done = 1'b1;
                    if (bus.round_out <= 4'(NR)) begin
                        got_key[bus.round_out]    = d_now;
                        got_vcycle[bus.round_out] = valid_cnt;
                    end
                end
            end
            prev_hold  = bus.valid_out && !bus.ready_in;
            prev_snap  = {bus.round_out, d_now};
            prev_valid = bus.valid_out;
        end
    end

    task automatic set_key(input logic [127:0] k);
        bus.K0_in = k[127:96];
        bus.K1_in = k[95:64];
        bus.K2_in = k[63:32];
        bus.K3_in = k[31:0];
    endtask

    task automatic check_idle_zero(input string name);
        check(name, 136'({bus.D0_out, bus.D1_out, bus.D2_out, bus.D3_out,
                          bus.round_out, bus.valid_out, bus.busy_out, bus.done_out}), '0);
    endtask

    // mode 0: ready always high (also high alongside start); 1: random ready;
    // 2: three-cycle stall at round 4; 3: foreign start pulse during round 3.
    task automatic run_expansion(input logic [127:0] key, input int mode);
        int stall;
        bit injected;
        bit got_done;
        bit expect_r5;
        model_expand(key);
        push_expected();
        @(posedge clk); #1;
        bus.start_in = 1'b1;
        set_key(key);
        bus.ready_in = (mode == 0);
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        set_key(rand_key());
        stall     = 0;
        injected  = 1'b0;
        got_done  = 1'b0;
        expect_r5 = 1'b0;
        for (int c = 0; c < 300 && !got_done; c++) begin
            if (expect_r5) begin
                check("resume_latency", 136'(bus.round_out), 136'(5));
                expect_r5 = 1'b0;
            end
            bus.start_in = 1'b0;
            case (mode)
                1: bus.ready_in = ($urandom_range(0, 3) != 0);
                2: begin
                    if (bus.round_out == 4'd4 && stall < 3) begin
                        bus.ready_in = 1'b0;
                        stall++;
                    end else begin
                        if (bus.round_out == 4'd4 && stall == 3) expect_r5 = 1'b1;
                        bus.ready_in = 1'b1;
                    end
                end
                3: begin
                    bus.ready_in = 1'b1;
                    if (bus.round_out == 4'd3 && !injected) begin
                        bus.start_in = 1'b1;
                        set_key(~key);
                        injected = 1'b1;
                    end
                end
                default: bus.ready_in = 1'b1;
            endcase
            @(posedge clk); #1;
            if (bus.done_out) got_done = 1'b1;
        end
        bus.start_in = 1'b0;
        bus.ready_in = 1'b0;
        if (!got_done) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done_out within cycle budget (mode %0d)", mode);
        end
        @(negedge clk);
        check("queue_drained", 136'(sb_q.size()), 136'(0));
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

    initial begin
        vectors     = 0;
        miscompares = 0;
        build_tables();
        rst_n        = 1'b0;
        bus.start_in = 1'b0;
        bus.ready_in = 1'b0;
        set_key('0);
        #23;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.ready_in = 1'b1;
            set_key(rand_key());
            check_idle_zero("post_reset_quiet");
        end
        bus.ready_in = 1'b0;

        run_expansion(FIPS_KEY, 0);
        check("fips_round0", 136'(got_key[0]), 136'(FIPS_KEY));
        check("fips_round1", 136'(got_key[1]), 136'(128'ha0fafe17_88542cb1_23a33939_2a6c7605));
        check("fips_round10", 136'(got_key[10]), 136'(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6));
        check("round10_valid_cycle", 136'(got_vcycle[10]), 136'(11));

        run_expansion(FIPS_KEY, 2);
        run_expansion(FIPS_KEY, 3);
        for (int i = 0; i < 4; i++) run_expansion(rand_key(), 1);

        // Abandon an expansion at round 6 with an asynchronous reset.
        model_expand(FIPS_KEY);
        push_expected();
        @(posedge clk); #1;
        bus.start_in = 1'b1;
        set_key(FIPS_KEY);
        bus.ready_in = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        for (int c = 0; c < 40 && bus.round_out != 4'd6; c++) begin
            @(posedge clk); #1;
        end
        check("reached_round6", 136'(bus.round_out), 136'(6));
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check_idle_zero("async_reset_outputs");
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        bus.ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_idle_zero("reset_no_resume");
        end
        bus.ready_in = 1'b0;

        run_expansion('0, 0);
        check("zero_key_round1", 136'(got_key[1]), 136'(128'h62636363_62636363_62636363_62636363));
        run_expansion(rand_key(), 1);
        run_expansion(rand_key(), 2);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
